poly_keyboard_state: RTL and testbench
======================================

POLY_KEYBOARD_STATE -- requirements
Module: poly_keyboard_state

Interface
REQ-001 Parameter NUM_VOICES, default 4, meaning number of simultaneously held notes tracked (legal range 1..8).
REQ-002 Parameter NOTE_W, default 5, meaning note code width; 0 = silent, 1..18 = C2..F3.
REQ-003 Parameter STEAL, default 1, meaning full-voice policy: 1 = replace the round-robin victim, 0 = drop the new key.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_code  input  8  PS/2 set-2 scan byte, valid only while new_keyboard_data = 1.
REQ-007 new_keyboard_data  input  1  one-cycle byte strobe.
REQ-008 notes  output  NUM_VOICES*NOTE_W  packed per-voice note codes; voice i occupies bits [i*NOTE_W +: NOTE_W].
REQ-009 voice_valid  output  NUM_VOICES  bit i = 1 when voice i holds a key.
REQ-010 last_note  output  NOTE_W  most recently pressed held note; 0 once that key is released.
REQ-011 held_count  output  4  number of set voice_valid bits.

Function
REQ-012 Parser FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (0xE0 then 0xF0); bytes are consumed only on strobe cycles.
REQ-013 Transitions: IDLE -0xF0-> BRK; IDLE -0xE0-> EXT; EXT -0xF0-> EXT_BRK; EXT/EXT_BRK -any other byte-> IDLE with no voice change; BRK -any byte-> IDLE.
REQ-014 Key map: Q,2,W,3,E,R,5,T,6,Y,7,U,I,9,O,0,P,[ = 0x15,0x1E,0x1D,0x26,0x24,0x2D,0x2E,0x2C,0x36,0x35,0x3D,0x3C,0x43,0x46,0x44,0x45,0x4D,0x54 -> notes 1..18; any other byte maps to 0 (unmapped).
REQ-015 Make (IDLE, mapped byte, note not held): write the note into the lowest-index free voice, set its valid bit, set last_note to the note.
REQ-016 Make of an already-held note (typematic repeat): no voice change; last_note unchanged.
REQ-017 Make with all voices valid: STEAL=1 overwrites voice at rr_ptr, increments rr_ptr modulo NUM_VOICES, sets last_note; STEAL=0 ignores the key.
REQ-018 Break (BRK, mapped byte): clear valid bit and zero the note of the voice holding that note; if it equals last_note, last_note becomes 0.
REQ-019 Break of a note not held, or unmapped make/break byte: no output change.
REQ-020 Latency: all outputs are registered and reflect a byte in the cycle after the strobe edge; a strobe each cycle is accepted back-to-back.
REQ-021 held_count always equals popcount(voice_valid); at most one voice holds any given note.

Reset
REQ-022 Reset asserted (any time, including mid-sequence): parser to IDLE, notes = 0, voice_valid = 0, last_note = 0, held_count = 0, rr_ptr = 0.
REQ-023 First strobe after reset deassertion is parsed from IDLE.

Structure
REQ-024 Shared package holds scan-code constants (0xF0, 0xE0, 18 key codes), note-code constants, and parser state encoding.
REQ-025 One combinational sub-module, scan_to_note, performs the REQ-014 mapping; voice allocation stays in the top.

Verification
REQ-026 Reset, then 0x15 -> notes[0]=1, voice_valid=0001, last_note=1, held_count=1.
REQ-027 0x15, 0x1D, 0xF0,0x15 -> voice0 cleared, voice1=3, last_note=3, held_count=1; then 0x26 fills voice0=4.
REQ-028 0x15 x3 (repeat) -> single voice holds 1, held_count=1.
REQ-029 NUM_VOICES=4, STEAL=1: keys 1..4 held, then 0x2D -> voice0=6, rr_ptr=1; STEAL=0 same stimulus -> notes unchanged.
REQ-030 0xE0,0x15 and 0xE0,0xF0,0x15 -> no output change; 0xF0,0x1C (unmapped) -> no change.
REQ-031 Reset asserted between 0xF0 and 0x15 -> all outputs 0; following 0x15 treated as make (voice0=1).

Source files
------------

// File: rtl/poly_keyboard_state_pkg.sv
// Shared constants for the polyphonic keyboard tracker: PS/2 set-2 scan codes,
// note codes and the scan-byte parser state encoding.
package poly_keyboard_state_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_Y     = 8'h35;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_U     = 8'h3C;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_O     = 8'h44;
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_LBRK  = 8'h54;

  localparam logic [4:0] NOTE_SILENT = 5'd0;
  localparam logic [4:0] NOTE_C2     = 5'd1;
  localparam logic [4:0] NOTE_CS2    = 5'd2;
  localparam logic [4:0] NOTE_D2     = 5'd3;
  localparam logic [4:0] NOTE_DS2    = 5'd4;
  localparam logic [4:0] NOTE_E2     = 5'd5;
  localparam logic [4:0] NOTE_F2     = 5'd6;
  localparam logic [4:0] NOTE_FS2    = 5'd7;
  localparam logic [4:0] NOTE_G2     = 5'd8;
  localparam logic [4:0] NOTE_GS2    = 5'd9;
  localparam logic [4:0] NOTE_A2     = 5'd10;
  localparam logic [4:0] NOTE_AS2    = 5'd11;
  localparam logic [4:0] NOTE_B2     = 5'd12;
  localparam logic [4:0] NOTE_C3     = 5'd13;
  localparam logic [4:0] NOTE_CS3    = 5'd14;
  localparam logic [4:0] NOTE_D3     = 5'd15;
  localparam logic [4:0] NOTE_DS3    = 5'd16;
  localparam logic [4:0] NOTE_E3     = 5'd17;
  localparam logic [4:0] NOTE_F3     = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } parse_state_t;

endpackage

// File: rtl/poly_keyboard_state_scan_to_note.sv
// Combinational map from a PS/2 set-2 scan byte to a note code (0 = unmapped).
module scan_to_note
  import poly_keyboard_state_pkg::*;
#(
  parameter int unsigned NOTE_W = 5
) (
  input  logic [7:0]        key_code,
  output logic [NOTE_W-1:0] note
);

  logic [4:0] note5;

  always_comb begin
    note5 = NOTE_SILENT;
    case (key_code)
      SC_Q:    note5 = NOTE_C2;
      SC_2:    note5 = NOTE_CS2;
      SC_W:    note5 = NOTE_D2;
      SC_3:    note5 = NOTE_DS2;
      SC_E:    note5 = NOTE_E2;
      SC_R:    note5 = NOTE_F2;
      SC_5:    note5 = NOTE_FS2;
      SC_T:    note5 = NOTE_G2;
      SC_6:    note5 = NOTE_GS2;
      SC_Y:    note5 = NOTE_A2;
      SC_7:    note5 = NOTE_AS2;
      SC_U:    note5 = NOTE_B2;
      SC_I:    note5 = NOTE_C3;
      SC_9:    note5 = NOTE_CS3;
      SC_O:    note5 = NOTE_D3;
      SC_0:    note5 = NOTE_DS3;
      SC_P:    note5 = NOTE_E3;
      SC_LBRK: note5 = NOTE_F3;
      default: note5 = NOTE_SILENT;
    endcase
  end

  assign note = NOTE_W'(note5);

endmodule

// File: rtl/poly_keyboard_state.sv
// Tracks up to NUM_VOICES held keys from a PS/2 scan-byte stream and assigns
// each newly pressed note to a voice slot, stealing round-robin when full.
module poly_keyboard_state
  import poly_keyboard_state_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = 5,
  parameter int          STEAL      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   key_code,
  input  logic                         new_keyboard_data,
  output logic [NUM_VOICES*NOTE_W-1:0] notes,
  output logic [NUM_VOICES-1:0]        voice_valid,
  output logic [NOTE_W-1:0]            last_note,
  output logic [3:0]                   held_count
);

  localparam int unsigned      PTR_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_VOICES - 1);

  parse_state_t      state;
  logic [NOTE_W-1:0] voice_note [NUM_VOICES];
  logic [PTR_W-1:0]  rr_ptr;
  logic [NOTE_W-1:0] key_note;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              has_free;
  logic [PTR_W-1:0]  free_idx;

  scan_to_note #(.NOTE_W(NOTE_W)) u_scan_to_note (
    .key_code (key_code),
    .note     (key_note)
  );

  // First match wins, so the lowest-index free voice is chosen.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (voice_valid[i] && (voice_note[i] == key_note) && !hit) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
      if (!voice_valid[i] && !has_free) begin
        has_free = 1'b1;
        free_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    notes = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      notes[i*NOTE_W +: NOTE_W] = voice_note[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      voice_valid <= '0;
      last_note   <= '0;
      held_count  <= '0;
      rr_ptr      <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        voice_note[i] <= '0;
      end
    end else if (new_keyboard_data) begin
      case (state)
        ST_IDLE: begin
          if (key_code == SC_BREAK) begin
            state <= ST_BRK;
          end else if (key_code == SC_EXT) begin
            state <= ST_EXT;
          end else if ((key_note != '0) && !hit) begin
            if (has_free) begin
              voice_note[free_idx]  <= key_note;
              voice_valid[free_idx] <= 1'b1;
              held_count            <= held_count + 4'd1;
              last_note             <= key_note;
            end else if (STEAL != 0) begin
              voice_note[rr_ptr] <= key_note;
              rr_ptr             <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + PTR_W'(1);
              last_note          <= key_note;
            end
          end
        end
        ST_BRK: begin
          state <= ST_IDLE;
          if ((key_note != '0) && hit) begin
            voice_note[hit_idx]  <= '0;
            voice_valid[hit_idx] <= 1'b0;
            held_count           <= held_count - 4'd1;
            if (key_note == last_note) begin
              last_note <= '0;
            end
          end
        end
        ST_EXT:     state <= (key_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_keyboard_state.sv
// Bench for poly_keyboard_state: a stealing and a dropping instance share one
// byte stream and are checked against a vector table and a reference model.
module tb_poly_keyboard_state;

  localparam int NV = 4;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    key;
  logic          stb;
  logic [19:0]   notes_s, notes_d;
  logic [3:0]    valid_s, valid_d;
  logic [4:0]    last_s, last_d;
  logic [3:0]    cnt_s, cnt_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poly_keyboard_state #(.NUM_VOICES(NV), .NOTE_W(NW), .STEAL(1)) u_steal (
    .clk(clk), .reset(reset), .key_code(key), .new_keyboard_data(stb),
    .notes(notes_s), .voice_valid(valid_s), .last_note(last_s), .held_count(cnt_s)
  );

  poly_keyboard_state #(.NUM_VOICES(NV), .NOTE_W(NW), .STEAL(0)) u_drop (
    .clk(clk), .reset(reset), .key_code(key), .new_keyboard_data(stb),
    .notes(notes_d), .voice_valid(valid_d), .last_note(last_d), .held_count(cnt_d)
  );

  // Reference model: index 0 steals, index 1 drops.
  logic [7:0] keymap [18] = '{8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36,
                              8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h54};
  int mn [2][NV];
  bit mv [2][NV];
  int ml [2];
  int mrr [2];
  bit saw_e0 [2];
  bit saw_f0 [2];

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 18; i++) if (keymap[i] == b) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NV; i++) begin mn[m][i] = 0; mv[m][i] = 0; end
      ml[m] = 0; mrr[m] = 0; saw_e0[m] = 0; saw_f0[m] = 0;
    end
  endtask

  task automatic model_byte(input int m, input logic [7:0] b);
    int n;
    int at;
    n = lookup(b);
    at = -1;
    if (saw_e0[m]) begin
      if (b == 8'hF0 && !saw_f0[m]) saw_f0[m] = 1;
      else begin saw_e0[m] = 0; saw_f0[m] = 0; end
    end else if (saw_f0[m]) begin
      saw_f0[m] = 0;
      if (n != 0) for (int i = 0; i < NV; i++) if (mv[m][i] && mn[m][i] == n) at = i;
      if (at >= 0) begin
        mv[m][at] = 0; mn[m][at] = 0;
        if (ml[m] == n) ml[m] = 0;
      end
    end else if (b == 8'hF0) begin
      saw_f0[m] = 1;
    end else if (b == 8'hE0) begin
      saw_e0[m] = 1;
    end else if (n != 0) begin
      bit held;
      held = 0;
      for (int i = 0; i < NV; i++) if (mv[m][i] && mn[m][i] == n) held = 1;
      if (!held) begin
        for (int i = 0; i < NV; i++) if (!mv[m][i] && at < 0) at = i;
        if (at < 0 && m == 0) begin at = mrr[m]; mrr[m] = (mrr[m] + 1) % NV; end
        if (at >= 0) begin mn[m][at] = n; mv[m][at] = 1; ml[m] = n; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic [19:0] en;
      logic [3:0]  ev;
      int          ec;
      string       who;
      en = '0; ev = '0; ec = 0;
      for (int i = 0; i < NV; i++) begin
        en[i*NW +: NW] = 5'(mn[m][i]);
        ev[i] = mv[m][i];
        ec += int'(mv[m][i]);
      end
      who = (m == 0) ? "steal" : "drop";
      chk({tag, "/", who, " notes"}, 32'((m == 0) ? notes_s : notes_d), 32'(en));
      chk({tag, "/", who, " valid"}, 32'((m == 0) ? valid_s : valid_d), 32'(ev));
      chk({tag, "/", who, " last"},  32'((m == 0) ? last_s  : last_d),  32'(ml[m]));
      chk({tag, "/", who, " count"}, 32'((m == 0) ? cnt_s   : cnt_d),   32'(ec));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit rst, input bit s, input logic [7:0] b);
    if (rst) begin
      stb = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async reset notes", 32'(notes_s), 32'h0);
      chk("async reset valid", 32'(valid_s), 32'h0);
      #1 reset = 1'b0;
    end else begin
      key = b;
      stb = s;
      if (s) begin model_byte(0, b); model_byte(1, b); end
    end
    @(negedge clk);
  endtask

  function automatic logic [19:0] pk(input logic [4:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  typedef struct {
    bit          rst;
    logic [7:0]  b;
    logic [19:0] notes;
    logic [3:0]  valid;
    logic [4:0]  last;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mkv(input bit r, input logic [7:0] b, input logic [19:0] n,
                               input logic [3:0] v, input logic [4:0] l, input logic [3:0] c);
    vec_t x;
    x.rst = r; x.b = b; x.notes = n; x.valid = v; x.last = l; x.cnt = c;
    return x;
  endfunction

  initial begin
    reset = 1'b1;
    stb   = 1'b0;
    key   = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset notes", 32'(notes_s), 32'h0);
    chk("reset valid", 32'(valid_s), 32'h0);
    chk("reset last",  32'(last_s),  32'h0);
    chk("reset count", 32'(cnt_s),   32'h0);
    check_model("reset");
    reset = 1'b0;
    @(negedge clk);

    tbl.push_back(mkv(0, 8'h15, pk(1,0,0,0), 4'h1, 1, 1));
    tbl.push_back(mkv(0, 8'h15, pk(1,0,0,0), 4'h1, 1, 1));
    tbl.push_back(mkv(0, 8'h15, pk(1,0,0,0), 4'h1, 1, 1));
    tbl.push_back(mkv(0, 8'h1D, pk(1,3,0,0), 4'h3, 3, 2));
    tbl.push_back(mkv(0, 8'hF0, pk(1,3,0,0), 4'h3, 3, 2));
    tbl.push_back(mkv(0, 8'h15, pk(0,3,0,0), 4'h2, 3, 1));
    tbl.push_back(mkv(0, 8'h26, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'hE0, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'h15, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'hE0, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'hF0, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'h26, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'hF0, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'h1C, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'hF0, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'h1E, pk(4,3,0,0), 4'h3, 4, 2));
    tbl.push_back(mkv(0, 8'h1E, pk(4,3,2,0), 4'h7, 2, 3));
    tbl.push_back(mkv(0, 8'h24, pk(4,3,2,5), 4'hF, 5, 4));
    tbl.push_back(mkv(0, 8'h2D, pk(6,3,2,5), 4'hF, 6, 4));
    tbl.push_back(mkv(0, 8'h2E, pk(6,7,2,5), 4'hF, 7, 4));
    tbl.push_back(mkv(0, 8'hF0, pk(6,7,2,5), 4'hF, 7, 4));
    tbl.push_back(mkv(0, 8'h2E, pk(6,0,2,5), 4'hD, 0, 3));
    tbl.push_back(mkv(1, 8'h00, pk(0,0,0,0), 4'h0, 0, 0));
    tbl.push_back(mkv(0, 8'hF0, pk(0,0,0,0), 4'h0, 0, 0));
    tbl.push_back(mkv(1, 8'h00, pk(0,0,0,0), 4'h0, 0, 0));
    tbl.push_back(mkv(0, 8'h15, pk(1,0,0,0), 4'h1, 1, 1));
    tbl.push_back(mkv(0, 8'hF0, pk(1,0,0,0), 4'h1, 1, 1));
    tbl.push_back(mkv(0, 8'h15, pk(0,0,0,0), 4'h0, 0, 0));

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].rst, !tbl[i].rst, tbl[i].b);
      chk({tag, " notes"}, 32'(notes_s), 32'(tbl[i].notes));
      chk({tag, " valid"}, 32'(valid_s), 32'(tbl[i].valid));
      chk({tag, " last"},  32'(last_s),  32'(tbl[i].last));
      chk({tag, " count"}, 32'(cnt_s),   32'(tbl[i].cnt));
      check_model(tag);
    end

    // Full voices: steal vs drop policy, then repeat of a stolen slot's new note.
    step(1, 0, 8'h00);
    step(0, 1, 8'h15); step(0, 1, 8'h1E); step(0, 1, 8'h1D); step(0, 1, 8'h26);
    step(0, 1, 8'h2D);
    chk("full steal notes", 32'(notes_s), 32'(pk(6,2,3,4)));
    chk("full steal last",  32'(last_s),  32'd6);
    chk("full drop notes",  32'(notes_d), 32'(pk(1,2,3,4)));
    chk("full drop last",   32'(last_d),  32'd4);
    chk("full drop count",  32'(cnt_d),   32'd4);
    step(0, 1, 8'h2D);
    chk("steal repeat notes", 32'(notes_s), 32'(pk(6,2,3,4)));
    step(0, 1, 8'h1C);
    step(0, 1, 8'h2E);
    chk("steal rr advance notes", 32'(notes_s), 32'(pk(6,7,3,4)));
    step(0, 1, 8'hF0); step(0, 1, 8'h15);
    chk("break stolen note", 32'(notes_s), 32'(pk(6,7,3,4)));
    check_model("full");

    for (int c = 0; c < 800; c++) begin
      int unsigned r;
      int unsigned k;
      logic [7:0]  b;
      r = $urandom_range(0, 199);
      k = $urandom_range(0, 99);
      if (k < 50)      b = keymap[$urandom_range(0, 17)];
      else if (k < 68) b = 8'hF0;
      else if (k < 76) b = 8'hE0;
      else             b = 8'($urandom);
      step(r == 0, r < 150, b);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
